unified_mem_arbiter: RTL and testbench

- Shares the single unified instruction/data memory between two requesters: instruction fetch (IF) and the MEM-stage load/store unit (D).
- Owns the one memory port: grants it, drives address/func3/write controls, and offsets data addresses into the data region.
- Performs load sign/zero extension and flags illegal accesses.
- Replaces clock-phase time-multiplexing of the memory with an explicit clocked request/acknowledge protocol; the pipeline stalls on a missing ack.

---
 rtl/unified_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the
// load/store unit, with a req/ack handshake, load extension and access checks.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_BASE   = 128,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int unsigned CntW   = $clog2(MAX_D_BURST + 1);
  localparam int unsigned WideW  = ADDR_W + 1;
  localparam logic [2:0]  F3Word = 3'b010;

  typedef enum logic [1:0] {StIdle, StRespI, StRespD} state_e;

  state_e          state_q;
  logic [CntW-1:0] burst_q;
  logic            err_q;
  logic            we_q;
  logic [2:0]      func3_q;

  logic             grant_i;
  logic             grant_d;
  logic             burst_full;
  logic             func3_bad;
  logic             range_bad;
  logic             d_bad;
  logic [WideW-1:0] d_phys;
  logic [WideW-1:0] d_end;

  assign burst_full = (burst_q == CntW'(MAX_D_BURST));

  // One extra bit so a word running past the top of memory is visible.
  assign d_phys    = {1'b0, d_addr} + WideW'(DATA_BASE);
  assign d_end     = d_phys + WideW'(3);
  assign range_bad = d_end[ADDR_W];
  assign func3_bad = d_we ? (d_func3 > F3Word)
                          : (d_func3 inside {3'b011, 3'b110, 3'b111});
  assign d_bad     = func3_bad | range_bad;

  // Gating with rst_n keeps the memory port quiet while reset is held.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst_n && (state_q == StIdle)) begin
      if (d_req && !(if_req && burst_full)) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_func3 = 3'b000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_i) begin
      mem_en    = 1'b1;
      mem_func3 = F3Word;
      mem_addr  = if_addr;
    end else if (grant_d && !d_bad) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_func3 = d_we ? d_func3 : F3Word;
      mem_addr  = d_phys[ADDR_W-1:0];
      mem_wdata = d_wdata;
    end
  end

  assign if_ack   = (state_q == StRespI);
  assign if_rdata = if_ack ? mem_rdata : '0;
  assign d_ack    = (state_q == StRespD);
  assign d_err    = d_ack & err_q;

  always_comb begin
    d_rdata = '0;
    if (d_ack && !err_q && !we_q) begin
      case (func3_q)
        3'b000:  d_rdata = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
        3'b001:  d_rdata = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
        3'b010:  d_rdata = mem_rdata;
        3'b100:  d_rdata = {24'b0, mem_rdata[7:0]};
        3'b101:  d_rdata = {16'b0, mem_rdata[15:0]};
        default: d_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      burst_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      func3_q <= 3'b000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_i) begin
            state_q <= StRespI;
            burst_q <= '0;
          end else if (grant_d) begin
            state_q <= StRespD;
            err_q   <= d_bad;
            we_q    <= d_we;
            func3_q <= d_func3;
            // Only D grants that made IF wait count toward the burst limit.
            if (!if_req) begin
              burst_q <= '0;
            end else if (!burst_full) begin
              burst_q <= burst_q + CntW'(1);
            end
          end else begin
            burst_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter: a byte-array memory device on the
// port, and a transaction-level reference model predicting grants and results.
module tb_unified_mem_arbiter;
  localparam int AW   = 12;
  localparam int BASE = 128;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [2:0]    d_func3;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic [31:0]   d_rdata;
  logic          d_err;
  logic          mem_en;
  logic          mem_we;
  logic [2:0]    mem_func3;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_BASE   (BASE),
    .MAX_D_BURST (MAXB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_func3   (d_func3),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_func3 (mem_func3),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [7:0] dev_mem [4096];
  logic [7:0] ref_mem [4096];
  logic       load_dev;

  int checks   = 0;
  int failures = 0;

  function automatic int nbytes(logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Memory device on the DUT port; read data appears the cycle after issue.
  always @(posedge clk) begin
    if (load_dev) begin
      for (int i = 0; i < 4096; i++) dev_mem[i] <= ref_mem[i];
    end else if (mem_en) begin
      if (mem_we) begin
        for (int k = 0; k < nbytes(mem_func3); k++)
          dev_mem[(int'(mem_addr) + k) % 4096] <= mem_wdata[8*k +: 8];
      end else begin
        for (int k = 0; k < 4; k++)
          mem_rdata[8*k +: 8] <= dev_mem[(int'(mem_addr) + k) % 4096];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Requester state and reference model state
  logic          if_pend, d_pend;
  logic [AW-1:0] i_addr_f, d_addr_f;
  logic          d_we_f;
  logic [2:0]    d_f3_f;
  logic [31:0]   d_wd_f;
  int            streak;
  logic          last_d_ack, last_d_err;
  logic [31:0]   last_d_rdata;

  function automatic bit illegal(input logic we, input logic [2:0] f3, input logic [AW-1:0] a);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    return (int'(a) + BASE + 3 >= 4096);
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    int v;
    case (f3)
      3'd0: begin v = int'(ref_mem[a]); if (v >= 128) v -= 256; end
      3'd1: begin v = int'({ref_mem[a+1], ref_mem[a]}); if (v >= 32768) v -= 65536; end
      3'd4: v = int'(ref_mem[a]);
      3'd5: v = int'({ref_mem[a+1], ref_mem[a]});
      default: v = int'(ref_word(a));
    endcase
    return 32'(v);
  endfunction

  task automatic drive();
    if_req  = if_pend;
    if_addr = i_addr_f;
    d_req   = d_pend;
    d_we    = d_we_f;
    d_func3 = d_f3_f;
    d_addr  = d_addr_f;
    d_wdata = d_wd_f;
  endtask

  // One arbitration slot: issue cycle then ack cycle, winner's request retired.
  task automatic run_slot();
    bit          win_d;
    bit          bad;
    int          phys;
    logic [31:0] exp_d;
    logic [31:0] exp_i;
    drive();
    @(negedge clk);
    if (!if_pend && !d_pend) begin
      check("idle_mem_en", 32'(mem_en), 0);
      check("idle_acks", 32'({if_ack, d_ack}), 0);
      streak = 0;
      @(posedge clk); #1;
      return;
    end
    win_d = d_pend && !(if_pend && streak == MAXB);
    phys  = int'(d_addr_f) + BASE;
    bad   = illegal(d_we_f, d_f3_f, d_addr_f);
    exp_d = 0;
    exp_i = 0;
    if (win_d) begin
      check("d_issue_en", 32'(mem_en), 32'(!bad));
      if (!bad) begin
        check("d_issue_addr", 32'(mem_addr), 32'(phys));
        check("d_issue_we", 32'(mem_we), 32'(d_we_f));
        check("d_issue_func3", 32'(mem_func3), d_we_f ? 32'(d_f3_f) : 32'd2);
        if (d_we_f) begin
          check("d_issue_wdata", mem_wdata, d_wd_f);
          for (int k = 0; k < nbytes(d_f3_f); k++) ref_mem[phys + k] = d_wd_f[8*k +: 8];
        end else begin
          exp_d = ref_load(d_f3_f, phys);
        end
      end
      streak = if_pend ? ((streak < MAXB) ? streak + 1 : MAXB) : 0;
    end else begin
      check("i_issue_en", 32'(mem_en), 1);
      check("i_issue_we", 32'(mem_we), 0);
      check("i_issue_func3", 32'(mem_func3), 2);
      check("i_issue_addr", 32'(mem_addr), 32'(i_addr_f));
      exp_i  = ref_word(int'(i_addr_f));
      streak = 0;
    end
    check("issue_acks", 32'({if_ack, d_ack}), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ack_no_issue", 32'(mem_en), 0);
    if (win_d) begin
      check("d_ack", 32'(d_ack), 1);
      check("d_if_ack", 32'(if_ack), 0);
      check("d_err", 32'(d_err), 32'(bad));
      check("d_rdata", d_rdata, exp_d);
      d_pend = 1'b0;
    end else begin
      check("if_ack", 32'(if_ack), 1);
      check("if_d_ack", 32'(d_ack), 0);
      check("if_rdata", if_rdata, exp_i);
      if_pend = 1'b0;
    end
    last_d_ack   = d_ack;
    last_d_err   = d_err;
    last_d_rdata = d_rdata;
    @(posedge clk); #1;
  endtask

  task automatic d_op(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                      input logic [31:0] wd);
    if_pend  = 1'b0;
    d_pend   = 1'b1;
    d_we_f   = we;
    d_f3_f   = f3;
    d_addr_f = a;
    d_wd_f   = wd;
    run_slot();
  endtask

  initial begin
    logic [9:0] order;
    rst_n    = 1'b0;
    load_dev = 1'b1;
    if_pend  = 1'b0;
    d_pend   = 1'b0;
    i_addr_f = '0;
    d_addr_f = '0;
    d_we_f   = 1'b0;
    d_f3_f   = 3'd0;
    d_wd_f   = '0;
    streak   = 0;
    order    = '0;
    drive();
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
    ref_mem[128] = 8'h11;
    ref_mem[129] = 8'h00;
    ref_mem[130] = 8'h00;
    ref_mem[131] = 8'h00;
    ref_mem[132] = 8'h80;
    ref_mem[133] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_acks", 32'({if_ack, d_ack, d_err}), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_d_rdata", d_rdata, 0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    load_dev = 1'b0;

    // Directed loads and stores
    d_op(1'b0, 3'd2, 12'd0, 32'h0);
    check("tp_lw", last_d_rdata, 32'h0000_0011);
    d_op(1'b0, 3'd0, 12'd4, 32'h0);
    check("tp_lb", last_d_rdata, 32'hFFFF_FF80);
    d_op(1'b0, 3'd4, 12'd4, 32'h0);
    check("tp_lbu", last_d_rdata, 32'h0000_0080);
    d_op(1'b0, 3'd1, 12'd4, 32'h0);
    check("tp_lh", last_d_rdata, 32'h0000_0080);
    d_op(1'b1, 3'd1, 12'd8, 32'hDEAD_BEEF);
    check("tp_sh_rdata", last_d_rdata, 0);
    d_op(1'b0, 3'd2, 12'd8, 32'h0);
    check("tp_lw_half", 32'(last_d_rdata[15:0]), 32'h0000_BEEF);

    // Illegal accesses, then confirm the target word was untouched
    d_op(1'b1, 3'd3, 12'd12, 32'h1234_5678);
    check("tp_bad_store", 32'(last_d_err), 1);
    d_op(1'b0, 3'd6, 12'd12, 32'h0);
    check("tp_bad_load", 32'(last_d_err), 1);
    d_op(1'b0, 3'd2, 12'd4094, 32'h0);
    check("tp_bad_range", 32'(last_d_err), 1);
    d_op(1'b0, 3'd2, 12'd12, 32'h0);

    // Both requesters held: burst limit forces IF in after MAXB D grants
    if_pend = 1'b0;
    d_pend  = 1'b0;
    run_slot();
    d_we_f   = 1'b0;
    d_f3_f   = 3'd2;
    d_addr_f = 12'd0;
    i_addr_f = 12'h100;
    for (int n = 0; n < 10; n++) begin
      if_pend = 1'b1;
      d_pend  = 1'b1;
      run_slot();
      order = {order[8:0], last_d_ack};
    end
    check("burst_order", 32'(order), 32'(10'b11110_11110));

    // Reset during the D response cycle suppresses the ack
    if_pend  = 1'b0;
    d_pend   = 1'b1;
    d_addr_f = 12'd0;
    drive();
    @(negedge clk);
    check("rst_mid_issue", 32'(mem_en), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_no_ack", 32'(d_ack), 0);
    check("rst_mid_mem_en", 32'(mem_en), 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    streak = 0;
    run_slot();
    check("rst_reissue_val", last_d_rdata, 32'h0000_0011);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!if_pend && ($urandom % 10) < 6) begin
        if_pend  = 1'b1;
        i_addr_f = ($urandom % 2 == 0) ? 12'($urandom_range(0, 1023) * 4)
                                       : 12'($urandom_range(32, 48) * 4);
      end
      if (!d_pend && ($urandom % 10) < 7) begin
        d_pend   = 1'b1;
        d_we_f   = 1'($urandom % 2);
        d_f3_f   = 3'($urandom % 8);
        d_addr_f = ($urandom % 10 == 0) ? 12'($urandom_range(4085, 4095))
                                        : 12'($urandom_range(0, 40));
        d_wd_f   = $urandom;
      end
      run_slot();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
